// File: rtl/video_timing_pkg.sv
// Shared types, standard mode constants and config validation for the raster timing generator.
package video_timing_pkg;

  // Config fields are sized for the widest supported counter; modules use the low CNT_W bits.
  localparam int unsigned CfgFieldW = 16;

  typedef logic [CfgFieldW-1:0] cfg_field_t;

  typedef struct packed {
    cfg_field_t h_sync;
    cfg_field_t h_back;
    cfg_field_t h_disp;
    cfg_field_t h_front;
    cfg_field_t v_sync;
    cfg_field_t v_back;
    cfg_field_t v_disp;
    cfg_field_t v_front;
  } timing_cfg_t;

  localparam timing_cfg_t Cfg1080p60 = '{
    h_sync: 16'd44, h_back: 16'd148, h_disp: 16'd1920, h_front: 16'd88,
    v_sync: 16'd5,  v_back: 16'd36,  v_disp: 16'd1080, v_front: 16'd4
  };

  localparam timing_cfg_t Cfg720p60 = '{
    h_sync: 16'd40, h_back: 16'd220, h_disp: 16'd1280, h_front: 16'd110,
    v_sync: 16'd5,  v_back: 16'd20,  v_disp: 16'd720,  v_front: 16'd5
  };

  // Two 1440-wide panels stitched side by side on a 1080-line raster.
  localparam timing_cfg_t Cfg2880x1080 = '{
    h_sync: 16'd44, h_back: 16'd148, h_disp: 16'd2880, h_front: 16'd88,
    v_sync: 16'd5,  v_back: 16'd36,  v_disp: 16'd1080, v_front: 16'd4
  };

  // A config is usable when no sync/disp is empty, both totals fit the counters and the
  // pixel request can be issued REQ_LEAD cycles before the first active column.
  function automatic logic timing_cfg_ok(input timing_cfg_t  cfg,
                                         input int unsigned  cnt_w,
                                         input int unsigned  req_lead);
    logic [31:0] h_tot;
    logic [31:0] v_tot;
    logic [31:0] max_tot;
    logic [31:0] h_lead;
    h_tot   = 32'(cfg.h_sync) + 32'(cfg.h_back) + 32'(cfg.h_disp) + 32'(cfg.h_front);
    v_tot   = 32'(cfg.v_sync) + 32'(cfg.v_back) + 32'(cfg.v_disp) + 32'(cfg.v_front);
    max_tot = (32'd1 << cnt_w) - 32'd1;
    h_lead  = 32'(cfg.h_sync) + 32'(cfg.h_back);
    return (cfg.h_disp != '0) && (cfg.v_disp != '0) &&
           (cfg.h_sync != '0) && (cfg.v_sync != '0) &&
           (h_tot <= max_tot) && (v_tot <= max_tot) &&
           (h_lead >= 32'(req_lead));
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Active/shadow timing config, frame-boundary apply and the h/v raster counters.
module video_timing_cnt import video_timing_pkg::*; #(
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned REQ_LEAD = 1,
  parameter timing_cfg_t DEF_CFG  = Cfg1080p60
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  timing_cfg_t      cfg_i,
  input  logic             cfg_valid_i,
  output logic             cfg_pending_o,
  output logic             cfg_err_o,
  output logic [CNT_W-1:0] cnt_h_o,
  output logic [CNT_W-1:0] cnt_v_o,
  output logic [CNT_W-1:0] h_sync_end_o,
  output logic [CNT_W-1:0] h_act_start_o,
  output logic [CNT_W-1:0] h_act_end_o,
  output logic [CNT_W-1:0] v_sync_end_o,
  output logic [CNT_W-1:0] v_act_start_o,
  output logic [CNT_W-1:0] v_act_end_o
);

  timing_cfg_t      active_q, active_d;
  timing_cfg_t      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0] cnt_v_q, cnt_v_d;
  logic [CNT_W-1:0] h_total, v_total;
  logic             h_last, v_last, cfg_ok;

  // Totals and window edges of the active config; validated configs never overflow CNT_W.
  assign h_total = CNT_W'(32'(active_q.h_sync) + 32'(active_q.h_back) +
                          32'(active_q.h_disp) + 32'(active_q.h_front));
  assign v_total = CNT_W'(32'(active_q.v_sync) + 32'(active_q.v_back) +
                          32'(active_q.v_disp) + 32'(active_q.v_front));

  assign h_sync_end_o  = CNT_W'(active_q.h_sync);
  assign h_act_start_o = CNT_W'(32'(active_q.h_sync) + 32'(active_q.h_back));
  assign h_act_end_o   = CNT_W'(32'(active_q.h_sync) + 32'(active_q.h_back) +
                                32'(active_q.h_disp));
  assign v_sync_end_o  = CNT_W'(active_q.v_sync);
  assign v_act_start_o = CNT_W'(32'(active_q.v_sync) + 32'(active_q.v_back));
  assign v_act_end_o   = CNT_W'(32'(active_q.v_sync) + 32'(active_q.v_back) +
                                32'(active_q.v_disp));

  assign h_last = (cnt_h_q == h_total - CNT_W'(1));
  assign v_last = (cnt_v_q == v_total - CNT_W'(1));
  assign cfg_ok = timing_cfg_ok(cfg_i, CNT_W, REQ_LEAD);

  // Counter advance, apply at the last pixel of the frame, then shadow capture (which must
  // come after the apply so a strobe in the apply cycle waits for the next boundary).
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    cnt_h_d   = cnt_h_q + CNT_W'(1);
    cnt_v_d   = cnt_v_q;
    err_d     = cfg_valid_i && !cfg_ok;
    if (h_last) begin
      cnt_h_d = '0;
      if (v_last) begin
        cnt_v_d   = '0;
        active_d  = shadow_q;
        pending_d = 1'b0;
      end else begin
        cnt_v_d = cnt_v_q + CNT_W'(1);
      end
    end
    if (cfg_valid_i && cfg_ok) begin
      shadow_d  = cfg_i;
      pending_d = 1'b1;
    end
  end

  // State registers; reset restores the default mode and drops any pending config.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q  <= DEF_CFG;
      shadow_q  <= DEF_CFG;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_h_q   <= '0;
      cnt_v_q   <= '0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      cnt_h_q   <= cnt_h_d;
      cnt_v_q   <= cnt_v_d;
    end
  end

  assign cfg_pending_o = pending_q;
  assign cfg_err_o     = err_q;
  assign cnt_h_o       = cnt_h_q;
  assign cnt_v_o       = cnt_v_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered sync/DE/RGB, lead-ahead pixel requests, frame/line
// markers and sticky underflow detection on top of the shadowed counter block.
module video_timing_gen import video_timing_pkg::*; #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned REQ_LEAD    = 1,
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0,
  parameter int unsigned DEF_H_SYNC  = 44,
  parameter int unsigned DEF_H_BACK  = 148,
  parameter int unsigned DEF_H_DISP  = 1920,
  parameter int unsigned DEF_H_FRONT = 88,
  parameter int unsigned DEF_V_SYNC  = 5,
  parameter int unsigned DEF_V_BACK  = 36,
  parameter int unsigned DEF_V_DISP  = 1080,
  parameter int unsigned DEF_V_FRONT = 4
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic [CNT_W-1:0]  cfg_h_sync,
  input  logic [CNT_W-1:0]  cfg_h_back,
  input  logic [CNT_W-1:0]  cfg_h_disp,
  input  logic [CNT_W-1:0]  cfg_h_front,
  input  logic [CNT_W-1:0]  cfg_v_sync,
  input  logic [CNT_W-1:0]  cfg_v_back,
  input  logic [CNT_W-1:0]  cfg_v_disp,
  input  logic [CNT_W-1:0]  cfg_v_front,
  input  logic              cfg_valid,
  output logic              cfg_pending,
  output logic              cfg_err,
  output logic              video_hs,
  output logic              video_vs,
  output logic              video_de,
  output logic [DATA_W-1:0] video_rgb,
  output logic              data_req,
  output logic [CNT_W-1:0]  pixel_xpos,
  output logic [CNT_W-1:0]  pixel_ypos,
  input  logic [DATA_W-1:0] pixel_data,
  input  logic              pixel_valid,
  output logic              frame_start,
  output logic              line_start,
  output logic              underflow,
  input  logic              underflow_clr
);

  localparam timing_cfg_t DefCfg = '{
    h_sync: CfgFieldW'(DEF_H_SYNC), h_back: CfgFieldW'(DEF_H_BACK),
    h_disp: CfgFieldW'(DEF_H_DISP), h_front: CfgFieldW'(DEF_H_FRONT),
    v_sync: CfgFieldW'(DEF_V_SYNC), v_back: CfgFieldW'(DEF_V_BACK),
    v_disp: CfgFieldW'(DEF_V_DISP), v_front: CfgFieldW'(DEF_V_FRONT)
  };
  localparam logic [CNT_W-1:0] ReqLead = CNT_W'(REQ_LEAD);

  timing_cfg_t      cfg_in;
  logic [CNT_W-1:0] cnt_h, cnt_v;
  logic [CNT_W-1:0] h_sync_end, h_act_start, h_act_end;
  logic [CNT_W-1:0] v_sync_end, v_act_start, v_act_end;
  logic [CNT_W-1:0] h_req_start, h_req_end;

  assign cfg_in = '{
    h_sync: CfgFieldW'(cfg_h_sync), h_back: CfgFieldW'(cfg_h_back),
    h_disp: CfgFieldW'(cfg_h_disp), h_front: CfgFieldW'(cfg_h_front),
    v_sync: CfgFieldW'(cfg_v_sync), v_back: CfgFieldW'(cfg_v_back),
    v_disp: CfgFieldW'(cfg_v_disp), v_front: CfgFieldW'(cfg_v_front)
  };

  video_timing_cnt #(
    .CNT_W    (CNT_W),
    .REQ_LEAD (REQ_LEAD),
    .DEF_CFG  (DefCfg)
  ) u_cnt (
    .clk_i         (pixel_clk),
    .rst_i         (sys_rst),
    .cfg_i         (cfg_in),
    .cfg_valid_i   (cfg_valid),
    .cfg_pending_o (cfg_pending),
    .cfg_err_o     (cfg_err),
    .cnt_h_o       (cnt_h),
    .cnt_v_o       (cnt_v),
    .h_sync_end_o  (h_sync_end),
    .h_act_start_o (h_act_start),
    .h_act_end_o   (h_act_end),
    .v_sync_end_o  (v_sync_end),
    .v_act_start_o (v_act_start),
    .v_act_end_o   (v_act_end)
  );

  // Validation guarantees h_act_start >= REQ_LEAD, so the request window stays in the line.
  assign h_req_start = h_act_start - ReqLead;
  assign h_req_end   = h_act_end - ReqLead;

  logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic              req_q, req_d, fs_q, fs_d, ls_q, ls_d;
  logic              uf_q, uf_d, v_act, uf_set;
  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;

  // Counter decode. de_d is high exactly in the cycle the source must present the pixel
  // requested REQ_LEAD-1 cycles earlier, so it also qualifies pixel_valid.
  always_comb begin
    v_act  = (cnt_v >= v_act_start) && (cnt_v < v_act_end);
    hs_d   = (cnt_h < h_sync_end) ? HS_POL : ~HS_POL;
    vs_d   = (cnt_v < v_sync_end) ? VS_POL : ~VS_POL;
    de_d   = v_act && (cnt_h >= h_act_start) && (cnt_h < h_act_end);
    req_d  = v_act && (cnt_h >= h_req_start) && (cnt_h < h_req_end);
    x_d    = req_d ? (cnt_h - h_req_start) : '0;
    y_d    = req_d ? (cnt_v - v_act_start) : '0;
    ls_d   = de_d && (cnt_h == h_act_start);
    fs_d   = ls_d && (cnt_v == v_act_start);
    rgb_d  = (de_d && pixel_valid) ? pixel_data : '0;
    uf_set = de_d && !pixel_valid;
    uf_d   = uf_set || (uf_q && !underflow_clr);
  end

  // Output registers.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      req_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
      rgb_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      req_q <= req_d;
      x_q   <= x_d;
      y_q   <= y_d;
      fs_q  <= fs_d;
      ls_q  <= ls_d;
      rgb_q <= rgb_d;
      uf_q  <= uf_d;
    end
  end

  assign video_hs    = hs_q;
  assign video_vs    = vs_q;
  assign video_de    = de_q;
  assign video_rgb   = rgb_q;
  assign data_req    = req_q;
  assign pixel_xpos  = x_q;
  assign pixel_ypos  = y_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign underflow   = uf_q;

endmodule
